// File: rtl/io_arb_pkg.sv
// Shared types and constants for the io_port bus arbiter.
// Master ids double as the 1-bit owner/last encoding.
package io_arb_pkg;

    localparam int IO_AW = 8;
    localparam int IO_DW = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/io_bus_arbiter_if.sv
// Two-requester handshake plus io_port bus signals for the arbiter.
// slave = arbiter side; master = requesters together with the io_port read path.
interface io_bus_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic          m0_req;
    logic          m1_req;
    logic          m0_we;
    logic          m1_we;
    logic [AW-1:0] m0_addr;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m0_wdata;
    logic [DW-1:0] m1_wdata;
    logic          m0_ack;
    logic          m1_ack;
    logic [DW-1:0] m0_rdata;
    logic [DW-1:0] m1_rdata;
    logic          io_en;
    logic          io_we;
    logic [AW-1:0] io_addr;
    logic [DW-1:0] io_data_write;
    logic [DW-1:0] io_data_read;

    modport slave (
        input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
        output m0_ack, m1_ack, m0_rdata, m1_rdata,
        output io_en, io_we, io_addr, io_data_write,
        input  io_data_read
    );

    modport master (
        output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
        input  m0_ack, m1_ack, m0_rdata, m1_rdata,
        input  io_en, io_we, io_addr, io_data_write,
        output io_data_read
    );

endinterface

// File: rtl/io_arb_pick.sv
// Combinational 2-way request picker.
// IO_ARB_FIXED_PRIO_EN: ties always go to m0; default: tie goes to the master that was not last.
module io_arb_pick
    import io_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic valid,
    output logic winner
);

`ifdef IO_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = last;

    always_comb begin
        valid  = req0 | req1;
        winner = req0 ? M0 : M1;
    end
`else
    always_comb begin
        valid  = req0 | req1;
        winner = req0 ? M0 : M1;
        if (req0 && req1) begin
            winner = ~last;
        end
    end
`endif

endmodule

// File: rtl/io_bus_arbiter.sv
// Arbitrates m0/m1 onto the single io_port bus, one 3-cycle transaction at a time.
// Tie-break policy lives in io_arb_pick (IO_ARB_FIXED_PRIO_EN selects fixed m0 priority).
//
// state  | meaning
// IDLE   | sample requests, latch winner's fields onto the bus
// ACCESS | bus cycle active; capture read data, raise owner's ack
// DONE   | ack visible for one cycle; record owner as last
module io_bus_arbiter
    import io_arb_pkg::*;
#(
    parameter int AW = IO_AW,
    parameter int DW = IO_DW
) (
    input  logic              clk,
    input  logic              resetb,
    io_bus_arbiter_if.slave   bus,
    output logic              busy
);

    arb_state_t    state;
    logic          owner;
    logic          last;
    logic          pick_valid;
    logic          pick_winner;
    logic          io_en_r;
    logic          io_we_r;
    logic [AW-1:0] io_addr_r;
    logic [DW-1:0] io_wdata_r;
    logic [DW-1:0] rdata0_r;
    logic [DW-1:0] rdata1_r;
    logic          ack0_r;
    logic          ack1_r;

    io_arb_pick u_pick (
        .req0   (bus.m0_req),
        .req1   (bus.m1_req),
        .last   (last),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state      <= IDLE;
            owner      <= M0;
            last       <= M1;
            io_en_r    <= 1'b0;
            io_we_r    <= 1'b0;
            io_addr_r  <= '0;
            io_wdata_r <= '0;
            rdata0_r   <= '0;
            rdata1_r   <= '0;
            ack0_r     <= 1'b0;
            ack1_r     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner   <= pick_winner;
                        io_en_r <= 1'b1;
                        if (pick_winner == M1) begin
                            io_we_r    <= bus.m1_we;
                            io_addr_r  <= bus.m1_addr;
                            io_wdata_r <= bus.m1_wdata;
                        end else begin
                            io_we_r    <= bus.m0_we;
                            io_addr_r  <= bus.m0_addr;
                            io_wdata_r <= bus.m0_wdata;
                        end
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    // io_port commits a write on this same edge; reads are captured here
                    if (!io_we_r) begin
                        if (owner == M1) rdata1_r <= bus.io_data_read;
                        else             rdata0_r <= bus.io_data_read;
                    end
                    if (owner == M1) ack1_r <= 1'b1;
                    else             ack0_r <= 1'b1;
                    io_en_r <= 1'b0;
                    io_we_r <= 1'b0;
                    state   <= DONE;
                end
                DONE: begin
                    ack0_r <= 1'b0;
                    ack1_r <= 1'b0;
                    last   <= owner;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.m0_ack        = ack0_r;
    assign bus.m1_ack        = ack1_r;
    assign bus.m0_rdata      = rdata0_r;
    assign bus.m1_rdata      = rdata1_r;
    assign bus.io_en         = io_en_r;
    assign bus.io_we         = io_we_r;
    assign bus.io_addr       = io_addr_r;
    assign bus.io_data_write = io_wdata_r;
    assign busy              = (state != IDLE);

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Self-checking bench for io_bus_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model (grant occupies 3 cycles, tie to non-last master).
module tb_io_bus_arbiter;

    logic clk = 1'b0;
    logic resetb = 1'b0;
    logic busy;
    int   n_checks = 0;
    int   n_fail = 0;

    logic        pre_en = 1'b0;
    logic [7:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;
    logic [31:0] io_mem [0:255];

    always #5 clk = ~clk;

    io_bus_arbiter_if #(.AW(8), .DW(32)) bus ();

    io_bus_arbiter #(.AW(8), .DW(32)) dut (
        .clk    (clk),
        .resetb (resetb),
        .bus    (bus),
        .busy   (busy)
    );

    // Fake io_port: flat word memory, combinational read, write on bus cycle.
    always @(posedge clk) begin
        if (!resetb) begin
            for (int i = 0; i < 256; i++) io_mem[i] <= '0;
        end else if (pre_en) begin
            io_mem[pre_addr] <= pre_data;
        end else if (bus.io_en && bus.io_we) begin
            io_mem[bus.io_addr] <= bus.io_data_write;
        end
    end
    assign bus.io_data_read = io_mem[bus.io_addr];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.m0_req = 1'b0; bus.m1_req = 1'b0;
        bus.m0_we = 1'b0; bus.m1_we = 1'b0;
        bus.m0_addr = '0; bus.m1_addr = '0;
        bus.m0_wdata = '0; bus.m1_wdata = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        resetb = 1'b0;
        tick();
        tick();
        resetb = 1'b1;
        tick();
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        pre_addr = a;
        pre_data = d;
        pre_en = 1'b1;
        tick();
        pre_en = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        bus.m0_we = 1'b1; bus.m0_addr = 8'h00; bus.m0_wdata = 32'hDEADBEEF;
        bus.m0_req = 1'b1;
        tick();
        n_checks++;
        if (bus.io_we !== 1'b1) begin n_fail++; $display("FAIL rst_pre_io_we: got %b want 1", bus.io_we); end
        resetb = 1'b0;
        #1;
        n_checks++;
        if (bus.io_we !== 1'b0) begin n_fail++; $display("FAIL rst_io_we: got %b want 0", bus.io_we); end
        n_checks++;
        if (bus.io_en !== 1'b0) begin n_fail++; $display("FAIL rst_io_en: got %b want 0", bus.io_en); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_checks++;
        if ({bus.m0_ack, bus.m1_ack} !== 2'b00) begin n_fail++; $display("FAIL rst_ack: got %b want 00", {bus.m0_ack, bus.m1_ack}); end
        n_checks++;
        if (bus.io_addr !== 8'h00 || bus.io_data_write !== 32'h0) begin
            n_fail++; $display("FAIL rst_bus: addr %h data %h want 0", bus.io_addr, bus.io_data_write);
        end
        n_checks++;
        if (bus.m0_rdata !== 32'h0 || bus.m1_rdata !== 32'h0) begin
            n_fail++; $display("FAIL rst_rdata: %h %h want 0", bus.m0_rdata, bus.m1_rdata);
        end
        bus.m0_req = 1'b0;
        tick();
        resetb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if ({bus.m0_ack, bus.m1_ack, busy} !== 3'b000) begin
                n_fail++; $display("FAIL rst_no_ack: ack/busy %b want 000", {bus.m0_ack, bus.m1_ack, busy});
            end
        end
    endtask

    task automatic test_write;
        do_reset();
        bus.m0_we = 1'b1; bus.m0_addr = 8'h00; bus.m0_wdata = 32'h000000A5;
        bus.m0_req = 1'b1;
        tick();
        n_checks++;
        if ({bus.io_en, bus.io_we, bus.m0_ack, busy} !== 4'b1101) begin
            n_fail++; $display("FAIL wr_access: en/we/ack/busy %b want 1101", {bus.io_en, bus.io_we, bus.m0_ack, busy});
        end
        n_checks++;
        if (bus.io_addr !== 8'h00 || bus.io_data_write !== 32'hA5) begin
            n_fail++; $display("FAIL wr_bus: addr %h data %h want 00 a5", bus.io_addr, bus.io_data_write);
        end
        tick();
        n_checks++;
        if ({bus.m0_ack, bus.io_en, bus.io_we} !== 3'b100) begin
            n_fail++; $display("FAIL wr_done: ack/en/we %b want 100", {bus.m0_ack, bus.io_en, bus.io_we});
        end
        n_checks++;
        if (io_mem[0] !== 32'hA5) begin n_fail++; $display("FAIL wr_output0: got %h want a5", io_mem[0]); end
        bus.m0_req = 1'b0;
        tick();
        n_checks++;
        if ({bus.m0_ack, busy} !== 2'b00) begin n_fail++; $display("FAIL wr_end: ack/busy %b want 00", {bus.m0_ack, busy}); end
    endtask

    task automatic test_read;
        do_reset();
        preload(8'h10, 32'h12345678);
        bus.m1_we = 1'b0; bus.m1_addr = 8'h10;
        bus.m1_req = 1'b1;
        tick();
        n_checks++;
        if ({bus.io_en, bus.io_we} !== 2'b10 || bus.io_addr !== 8'h10) begin
            n_fail++; $display("FAIL rd_access: en/we %b addr %h want 10 10", {bus.io_en, bus.io_we}, bus.io_addr);
        end
        tick();
        n_checks++;
        if ({bus.m1_ack, bus.m0_ack} !== 2'b10) begin
            n_fail++; $display("FAIL rd_ack: m1/m0 %b want 10", {bus.m1_ack, bus.m0_ack});
        end
        n_checks++;
        if (bus.m1_rdata !== 32'h12345678) begin n_fail++; $display("FAIL rd_m1_rdata: got %h want 12345678", bus.m1_rdata); end
        n_checks++;
        if (bus.m0_rdata !== 32'h0) begin n_fail++; $display("FAIL rd_m0_rdata: got %h want 0", bus.m0_rdata); end
        bus.m1_req = 1'b0;
        tick();
        n_checks++;
        if (bus.m1_ack !== 1'b0 || bus.m1_rdata !== 32'h12345678) begin
            n_fail++; $display("FAIL rd_hold: ack %b rdata %h want 0 12345678", bus.m1_ack, bus.m1_rdata);
        end
    endtask

    task automatic test_alternate;
        int got [$];
        int want [4];
`ifdef IO_ARB_FIXED_PRIO_EN
        want = '{0, 0, 0, 0};
`else
        want = '{0, 1, 0, 1};
`endif
        do_reset();
        bus.m0_addr = 8'h02; bus.m1_addr = 8'h03;
        bus.m0_req = 1'b1; bus.m1_req = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.m0_ack && bus.m1_ack) begin
                n_checks++; n_fail++; $display("FAIL alt_both_ack: both acks high at cycle %0d", i);
            end
            if (bus.m0_ack) got.push_back(0);
            if (bus.m1_ack) got.push_back(1);
        end
        n_checks++;
        if (got.size() !== 4) begin n_fail++; $display("FAIL alt_count: got %0d acks want 4", got.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) begin
                n_checks++;
                if (got[i] !== want[i]) begin n_fail++; $display("FAIL alt_order[%0d]: got m%0d want m%0d", i, got[i], want[i]); end
            end
        end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_late_req;
        int  cnt;
        bit  found;
        do_reset();
        bus.m0_we = 1'b1; bus.m0_addr = 8'h04; bus.m0_wdata = 32'hCAFE0042;
        bus.m0_req = 1'b1;
        tick();
        bus.m1_we = 1'b0; bus.m1_addr = 8'h04;
        bus.m1_req = 1'b1;
        tick();
        n_checks++;
        if ({bus.m0_ack, bus.m1_ack} !== 2'b10) begin
            n_fail++; $display("FAIL late_m0_ack: m0/m1 %b want 10", {bus.m0_ack, bus.m1_ack});
        end
        bus.m0_req = 1'b0;
        cnt = 0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            cnt++;
            if (bus.m1_ack) found = 1'b1;
        end
        n_checks++;
        if (!found || cnt != 3) begin n_fail++; $display("FAIL late_m1_delay: found %0d after %0d cycles want 3", found, cnt); end
        n_checks++;
        if (bus.m1_rdata !== 32'hCAFE0042) begin n_fail++; $display("FAIL late_m1_rdata: got %h want cafe0042", bus.m1_rdata); end
        bus.m1_req = 1'b0;
        tick();
    endtask

    task automatic test_dir_read;
        do_reset();
        preload(8'h01, 32'h00000F00);
        bus.m0_we = 1'b0; bus.m0_addr = 8'h01;
        bus.m0_req = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_checks++;
            if (bus.io_we !== 1'b0) begin n_fail++; $display("FAIL dir_io_we[%0d]: got %b want 0", i, bus.io_we); end
            if (i == 2) begin
                n_checks++;
                if (bus.m0_ack !== 1'b1 || bus.m0_rdata[15:8] !== 8'h0F) begin
                    n_fail++; $display("FAIL dir_rdata: ack %b rdata[15:8] %h want 1 0f", bus.m0_ack, bus.m0_rdata[15:8]);
                end
                bus.m0_req = 1'b0;
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] model_mem [0:7];
        bit          rq [2];
        bit          rwe [2];
        logic [7:0]  raddr [2];
        logic [31:0] rwd [2];
        logic [31:0] exp_rd [2];
        bit          exp_ack [2];
        int          g;
        int          d;
        bit          gw, gwe, mlast;
        bit          e_en, e_we, e_busy;
        logic [7:0]  gaddr;
        logic [31:0] gwd, gres, v;
        do_reset();
        for (int a = 0; a < 8; a++) begin
            v = $urandom;
            model_mem[a] = v;
            preload(8'(a), v);
        end
        g = -10; mlast = 1'b1; gw = 1'b0; gwe = 1'b0; gaddr = '0; gwd = '0; gres = '0;
        for (int i = 0; i < 2; i++) begin
            rq[i] = 1'b0; rwe[i] = 1'b0; raddr[i] = '0; rwd[i] = '0; exp_rd[i] = '0;
        end
        for (int n = 0; n < 400; n++) begin
            d = n - g;
            e_en = (d == 0);
            e_we = e_en && gwe;
            e_busy = (d == 0) || (d == 1);
            exp_ack[0] = (d == 1) && (gw == 1'b0);
            exp_ack[1] = (d == 1) && (gw == 1'b1);
            if (d == 1 && !gwe) exp_rd[gw] = gres;
            n_checks++;
            if ({bus.io_en, bus.io_we, busy} !== {e_en, e_we, e_busy}) begin
                n_fail++; $display("FAIL rnd_ctrl@%0d: en/we/busy %b want %b", n, {bus.io_en, bus.io_we, busy}, {e_en, e_we, e_busy});
            end
            n_checks++;
            if (bus.io_addr !== gaddr || bus.io_data_write !== gwd) begin
                n_fail++; $display("FAIL rnd_bus@%0d: addr %h data %h want %h %h", n, bus.io_addr, bus.io_data_write, gaddr, gwd);
            end
            n_checks++;
            if ({bus.m0_ack, bus.m1_ack} !== {exp_ack[0], exp_ack[1]}) begin
                n_fail++; $display("FAIL rnd_ack@%0d: m0/m1 %b want %b", n, {bus.m0_ack, bus.m1_ack}, {exp_ack[0], exp_ack[1]});
            end
            n_checks++;
            if (bus.m0_rdata !== exp_rd[0] || bus.m1_rdata !== exp_rd[1]) begin
                n_fail++; $display("FAIL rnd_rdata@%0d: %h %h want %h %h", n, bus.m0_rdata, bus.m1_rdata, exp_rd[0], exp_rd[1]);
            end
            for (int i = 0; i < 2; i++) begin
                if (exp_ack[i]) rq[i] = 1'b0;
                if (!rq[i] && $urandom_range(0, 2) == 0) begin
                    rq[i] = 1'b1;
                    rwe[i] = 1'($urandom_range(0, 1));
                    raddr[i] = 8'($urandom_range(0, 7));
                    rwd[i] = $urandom;
                end
            end
            bus.m0_req = rq[0]; bus.m0_we = rwe[0]; bus.m0_addr = raddr[0]; bus.m0_wdata = rwd[0];
            bus.m1_req = rq[1]; bus.m1_we = rwe[1]; bus.m1_addr = raddr[1]; bus.m1_wdata = rwd[1];
            // The arbiter is free to grant again three edges after its previous grant.
            if (n + 1 >= g + 3 && (rq[0] || rq[1])) begin
`ifdef IO_ARB_FIXED_PRIO_EN
                gw = rq[0] ? 1'b0 : 1'b1;
`else
                if (rq[0] && rq[1]) gw = !mlast;
                else                gw = rq[0] ? 1'b0 : 1'b1;
`endif
                mlast = gw;
                g = n + 1;
                gwe = rwe[gw];
                gaddr = raddr[gw];
                gwd = rwd[gw];
                if (gwe) model_mem[gaddr[2:0]] = gwd;
                else     gres = model_mem[gaddr[2:0]];
            end
            tick();
        end
        idle_inputs();
        tick();
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_write();
        test_read();
        test_alternate();
        test_late_req();
        test_dir_read();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
